// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage in front of a combinational-read instruction
// memory. Holds the PC, captures {PC, word} into a small fetch queue, presents
// the queue head to decode, and restarts fetch on a redirect.
//
// Optional build macro IF_MISALIGN_TRAP_EN: adds the misaligned output and a
// halted flag that blocks fetch after a misaligned redirect target until the
// next aligned redirect.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A
// transfer happens on a rising edge where both are high. While out_valid is
// high and out_ready is low, out_instruction and out_pc do not change.
// A redirect at an edge flushes the queue, so any transfer offered in that
// cycle is discarded rather than delivered.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] addr,
  input  logic [31:0] instruction,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
`ifdef IF_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic [31:0] out_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];

  logic push;
  logic pop;
  logic fetch_en;

`ifdef IF_MISALIGN_TRAP_EN
  logic halted;
  assign fetch_en = ~halted;
`else
  assign fetch_en = 1'b1;
`endif

  // Memory address and head outputs come straight from registers.
  assign addr            = pc;
  assign out_valid       = (count != '0);
  assign out_instruction = instr_q[rd_ptr];
  assign out_pc          = pc_q[rd_ptr];

  // Push and pop qualifiers; a full queue can still accept when head leaves.
  always_comb begin
    pop  = out_valid & out_ready;
    push = ~redirect & fetch_en & ((count < DEPTH_C) | pop);
  end

  // PC register: redirect target (word aligned) wins over sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  // Queue pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage: captures the current PC with the word memory returns for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr] <= instruction;
      pc_q[wr_ptr]    <= pc;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // Misaligned redirect: one-cycle pulse, and fetch stays halted until an
  // aligned redirect arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted     <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect & (redirect_pc[1:0] != 2'b00);
      if (redirect) halted <= (redirect_pc[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch (DEPTH = 2, RESET_PC = 0).
// The instruction memory is a combinational model inside the bench; every
// expected value below is hand-derived from the fetch/queue rules.
module tb_instruction_fetch;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] instruction;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .addr            (addr),
    .instruction     (instruction),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
`ifdef IF_MISALIGN_TRAP_EN
    .misaligned      (misaligned),
`endif
    .out_pc          (out_pc)
  );

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0013;
      32'h0000_0004: mem_word = 32'h0010_0093;
      32'h0000_0008: mem_word = 32'h0020_0113;
      default:       mem_word = ~a;
    endcase
  endfunction

  always_comb instruction = mem_word(addr);

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the head of the queue: valid, PC and the word memory holds there.
  task automatic check_head(input string tag, input logic [31:0] exp_pc);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_pc"},    out_pc,             exp_pc);
    check({tag, "_instr"}, out_instruction,    mem_word(exp_pc));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n       = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #12;

    // Reset state
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_addr",  addr,               32'h0);
    check("rst_pc",    out_pc,             32'h0);
    check("rst_instr", out_instruction,    32'h0);
`ifdef IF_MISALIGN_TRAP_EN
    check("rst_mis",   {31'd0, misaligned}, 32'd0);
`endif

    // Release reset with decode ready: PCs 0,4,8 back to back
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check_head("run0", 32'h0);
    check("run0_addr", addr, 32'h4);
    tick();
    check_head("run1", 32'h4);
    tick();
    check_head("run2", 32'h8);

    // Asynchronous reset mid-operation: entries lost immediately
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_addr",  addr,               32'h0);
    check("async_rst_instr", out_instruction,    32'h0);

    // Backpressure: queue fills with PCs 0,4 and Addr holds at 8
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_head("bp1", 32'h0);
    check("bp1_addr", addr, 32'h4);
    tick();
    check_head("bp2", 32'h0);
    check("bp2_addr", addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_head("bp_hold", 32'h0);
      check("bp_hold_addr", addr, 32'h8);
    end

    // Full queue drained with ready: push and pop together, no gaps
    out_ready = 1'b1;
    tick();
    check_head("drain1", 32'h4);
    check("drain1_addr", addr, 32'hC);
    tick();
    check_head("drain2", 32'h8);
    check("drain2_addr", addr, 32'h10);
    tick();
    check_head("drain3", 32'hC);

    // Redirect to 0x40 with two entries queued and ready high
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("redir_valid", {31'd0, out_valid}, 32'd0);
    check("redir_addr",  addr,               32'h40);
    tick();
    check_head("redir_head", 32'h40);
    tick();
    check_head("redir_next", 32'h44);

    // PC wrap at top of address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_addr", addr, 32'hFFFF_FFFC);
    tick();
    check_head("wrap_top", 32'hFFFF_FFFC);
    check("wrap_addr0", addr, 32'h0);
    tick();
    check_head("wrap_zero", 32'h0);

    // Misaligned redirect target
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
    check("mis_addr",  addr,               32'h40);
    check("mis_valid", {31'd0, out_valid}, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
    check("mis_pulse", {31'd0, misaligned}, 32'd1);
    tick();
    check("mis_pulse_end", {31'd0, misaligned}, 32'd0);
    check("mis_halt_valid", {31'd0, out_valid}, 32'd0);
    check("mis_halt_addr",  addr,               32'h40);
    tick();
    check("mis_halt_valid2", {31'd0, out_valid}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    check("resume_addr", addr, 32'h80);
    check("resume_mis",  {31'd0, misaligned}, 32'd0);
    tick();
    check_head("resume_head", 32'h80);
`else
    tick();
    check_head("mis_ignored", 32'h40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction memory.
- Holds the PC and drives it as the byte address into the combinational-read instruction memory.
- Captures the returned 32-bit word with its PC into a small fetch queue.
- Presents queue entries to decode through a valid/ready handshake.
- Accepts redirects (branch/jump/trap targets) that flush the queue and restart fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, fetch-queue entries; power of two, >= 2.

Ports:
Clk  in  1  rising-edge clock.
Rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
Addr  out  32  byte address to instruction memory; always equals PC.
Instruction  in  32  word returned by instruction memory for Addr; valid in the same cycle.
Redirect  in  1  load Redirect_PC into PC and flush the queue.
Redirect_PC  in  32  redirect target.
Out_Valid  out  1  queue head holds a valid instruction.
Out_Ready  in  1  decode accepts head this cycle.
Out_Instruction  out  32  head instruction word.
Out_PC  out  32  PC of the head instruction.
Misaligned  out  1  only when IF_MISALIGN_TRAP_EN is defined; see Optional Feature.

Behaviour:
- Reset (Rst_n low, async):
  - PC = RESET_PC.
  - Queue count, read pointer and write pointer = 0.
  - All queue storage = 0.
  - Out_Valid = 0, Out_Instruction = 0, Out_PC = 0, Misaligned = 0.
- Addr = PC, combinational from the PC register.
- Out_Valid = (count != 0). Out_Instruction and Out_PC are read combinationally from queue storage at the read pointer.
- pop = Out_Valid & Out_Ready.
- push = ~Redirect & (count < DEPTH | pop).
  - With IF_MISALIGN_TRAP_EN defined, push is additionally gated by ~halted.
- On push, at the clock edge:
  - Write {PC, Instruction} at the write pointer; the write pointer advances.
  - PC <= PC + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Queue full (count == DEPTH), no pop: no push; PC holds; Addr is stable.
- Simultaneous push and pop (including when full): count is unchanged; both pointers advance modulo DEPTH.
- Empty with Out_Ready high: no pop and no underflow; Out_Instruction and Out_PC hold their last storage contents.
- Head stability: while Out_Valid = 1 and Out_Ready = 0, Out_Instruction and Out_PC must not change.
- Redirect = 1, sampled at the edge:
  - PC <= {Redirect_PC[31:2], 2'b00}.
  - count and both pointers <= 0.
  - No push that cycle. A concurrent pop is discarded: the entry is flushed, not delivered.
  - Redirect has priority over push and pop.
- Redirect latency: Redirect sampled at edge n; Addr = target during cycle n+1; push at edge n+1; Out_Valid = 1 in cycle n+2.
- Reset latency: first push at the first edge after Rst_n deasserts; Out_Valid = 1 after that edge with Out_PC = RESET_PC.
- Steady state, Out_Ready held at 1: one instruction delivered per cycle; PCs increase by 4 with no bubbles.
- Reset mid-operation: immediate return to reset state; all queued entries are lost.

Optional Feature:
Macro: IF_MISALIGN_TRAP_EN
- Defined:
  - Output Misaligned exists.
  - A redirect with Redirect_PC[1:0] != 0 still loads the aligned PC and flushes the queue.
  - It also sets halted: no pushes occur while halted.
  - Misaligned = 1 for exactly the cycle after that edge, and halted holds.
  - The next redirect with aligned Redirect_PC clears halted and fetch resumes normally.
- Not defined:
  - No Misaligned port and no halted state.
  - Redirect_PC[1:0] is silently ignored.

Test Plan:
- Reset release, memory words at 0/4/8 = 0x00000013/0x00100093/0x00200113, Out_Ready = 1 -> Out_Valid from cycle 1; Out_PC 0,4,8 on consecutive cycles with the matching words.
- Out_Ready = 0 for 5 cycles after reset (DEPTH = 2) -> queue fills with PCs 0,4; Addr holds at 8; head stays PC 0. Raise Out_Ready -> PCs 0,4,8 delivered back-to-back, no gaps or duplicates.
- Queue full, Out_Ready = 1 -> pushes and pops together each cycle; count stays 2; no lost entries.
- Redirect = 1 with Redirect_PC = 0x40 while the queue holds 2 entries and Out_Ready = 1 -> Out_Valid = 0 next cycle; Addr = 0x40; Out_PC = 0x40 two cycles after the redirect.
- Redirect_PC = 0xFFFFFFFC -> delivered PCs 0xFFFFFFFC then 0x00000000.
- IF_MISALIGN_TRAP_EN defined, Redirect_PC = 0x42 -> Misaligned pulses for 1 cycle; Addr = 0x40; Out_Valid stays 0. Then Redirect_PC = 0x80 -> fetch resumes with Out_PC = 0x80. Macro undefined, Redirect_PC = 0x42 -> Out_PC = 0x40.
